// File: rtl/soc_pmc_pulse_gen.sv
// Gate/strobe sequencer for the pixel matrix controller. A shared timing profile
// (gate width, strobe window, gap, repeat count) drives a set of maskable channels.
module soc_pmc_pulse_gen #(
    parameter int CHANNELS  = 1,
    parameter int CNT_WIDTH = 16,
    parameter int REP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHANNELS-1:0]  ch_mask,
    input  logic [CNT_WIDTH-1:0] gate_len,
    input  logic [CNT_WIDTH-1:0] strobe_delay,
    input  logic [CNT_WIDTH-1:0] strobe_len,
    input  logic [CNT_WIDTH-1:0] gap_len,
    input  logic [REP_WIDTH-1:0] repeats,
    output logic [CHANNELS-1:0]  gate,
    output logic [CHANNELS-1:0]  strobe,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REP_WIDTH-1:0] REP_ZERO = {REP_WIDTH{1'b0}};
    localparam logic [REP_WIDTH-1:0] REP_ONE  = {{(REP_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r, state_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
    logic [REP_WIDTH-1:0]   pulse_r, pulse_s;
    logic [CHANNELS-1:0]    mask_r, mask_s;
    logic [CNT_WIDTH-1:0]   gate_len_r, gate_len_s;
    logic [CNT_WIDTH-1:0]   sdel_r, sdel_s;
    logic [CNT_WIDTH-1:0]   slen_r, slen_s;
    logic [CNT_WIDTH-1:0]   gap_r, gap_s;
    logic [CNT_WIDTH-1:0]   gap_last_s;
    logic                   load_s;
    logic                   done_s;
    logic [CHANNELS-1:0]    gate_s, strobe_s;

    // Strobe window end is formed one bit wider so delay+length can never wrap.
    function automatic logic in_window(
        input logic [CNT_WIDTH-1:0] c,
        input logic [CNT_WIDTH-1:0] d,
        input logic [CNT_WIDTH-1:0] l,
        input logic [CNT_WIDTH-1:0] g
    );
        logic [CNT_WIDTH:0] end_v;
        end_v = {1'b0, d} + {1'b0, l};
        return (c >= d) && ({1'b0, c} < end_v) && (c < g);
    endfunction

    // Next-state, counter and config selection.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pulse_s    = pulse_r;
        load_s     = 1'b0;
        done_s     = 1'b0;
        gap_last_s = CNT_ZERO;
        if (gap_r == CNT_ZERO) begin
            gap_last_s = CNT_ZERO;
        end else begin
            gap_last_s = gap_r - CNT_ONE;
        end
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    if (gate_len != CNT_ZERO) begin
                        load_s  = 1'b1;
                        state_s = GATE;
                        cnt_s   = CNT_ZERO;
                        pulse_s = repeats;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            GATE: begin
                if (abort) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == gate_len_r - CNT_ONE) begin
                    cnt_s = CNT_ZERO;
                    if (pulse_r == REP_ZERO) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = GAP;
                        pulse_s = pulse_r - REP_ONE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == gap_last_s) begin
                    state_s = GATE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                pulse_s = REP_ZERO;
            end
        endcase

        if (load_s) begin
            mask_s     = ch_mask;
            gate_len_s = gate_len;
            sdel_s     = strobe_delay;
            slen_s     = strobe_len;
            gap_s      = gap_len;
        end else begin
            mask_s     = mask_r;
            gate_len_s = gate_len_r;
            sdel_s     = sdel_r;
            slen_s     = slen_r;
            gap_s      = gap_r;
        end
    end

    // Output values for the upcoming cycle, so gate/strobe leave a flop directly.
    always_comb begin
        gate_s   = {CHANNELS{1'b0}};
        strobe_s = {CHANNELS{1'b0}};
        if (state_s == GATE) begin
            gate_s = mask_s;
            if (in_window(cnt_s, sdel_s, slen_s, gate_len_s)) begin
                strobe_s = mask_s;
            end else begin
                strobe_s = {CHANNELS{1'b0}};
            end
        end else begin
            gate_s   = {CHANNELS{1'b0}};
            strobe_s = {CHANNELS{1'b0}};
        end
    end

    // State, counters, latched profile and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            pulse_r    <= REP_ZERO;
            mask_r     <= {CHANNELS{1'b0}};
            gate_len_r <= CNT_ZERO;
            sdel_r     <= CNT_ZERO;
            slen_r     <= CNT_ZERO;
            gap_r      <= CNT_ZERO;
            gate       <= {CHANNELS{1'b0}};
            strobe     <= {CHANNELS{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pulse_r    <= pulse_s;
            mask_r     <= mask_s;
            gate_len_r <= gate_len_s;
            sdel_r     <= sdel_s;
            slen_r     <= slen_s;
            gap_r      <= gap_s;
            gate       <= gate_s;
            strobe     <= strobe_s;
            busy       <= (state_s != IDLE);
            done       <= done_s;
        end
    end

endmodule

// File: tb/tb_soc_pmc_pulse_gen.sv
// Randomised scoreboard bench for soc_pmc_pulse_gen: a per-cycle reference trace is
// built from the timing rules, queued by the driver and checked by a separate monitor.
module tb_soc_pmc_pulse_gen;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CH-1:0] ch_mask = '0;
    logic [15:0]   gate_len = '0, strobe_delay = '0, strobe_len = '0, gap_len = '0;
    logic [7:0]    repeats = '0;
    logic [CH-1:0] gate, strobe;
    logic          busy, done;

    typedef struct packed {
        logic [CH-1:0] g;
        logic [CH-1:0] s;
        logic          b;
        logic          d;
    } exp_t;

    exp_t sb[$];
    exp_t model[$];
    int   vectors = 0;
    int   miscompares = 0;

    soc_pmc_pulse_gen #(.CHANNELS(CH), .CNT_WIDTH(16), .REP_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
        .gate_len(gate_len), .strobe_delay(strobe_delay), .strobe_len(strobe_len),
        .gap_len(gap_len), .repeats(repeats),
        .gate(gate), .strobe(strobe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per output cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({gate, strobe, busy, done} !== e) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got gate=%b strobe=%b busy=%b done=%b, want gate=%b strobe=%b busy=%b done=%b",
                         $time, gate, strobe, busy, done, e.g, e.s, e.b, e.d);
            end
        end
    end

    // Reference trace: output of each cycle after the start is sampled.
    task automatic build_model(input logic [CH-1:0] m, input int gl, input int sd,
                               input int sl, input int gp, input int rep);
        exp_t e;
        int   gap_cycles;
        model.delete();
        if (gl == 0) begin
            e = '{g: '0, s: '0, b: 1'b0, d: 1'b1};
            model.push_back(e);
            return;
        end
        gap_cycles = (gp == 0) ? 1 : gp;
        for (int k = 0; k <= rep; k++) begin
            for (int j = 0; j < gl; j++) begin
                e = '{g: m, s: ((j >= sd) && (j < sd + sl)) ? m : '0, b: 1'b1, d: 1'b0};
                model.push_back(e);
            end
            if (k < rep) begin
                for (int j = 0; j < gap_cycles; j++) begin
                    e = '{g: '0, s: '0, b: 1'b1, d: 1'b0};
                    model.push_back(e);
                end
            end
        end
        e = '{g: '0, s: '0, b: 1'b0, d: 1'b1};
        model.push_back(e);
    endtask

    // Drive one sequence; junk starts and config changes are thrown in while busy.
    task automatic run_seq(input logic [CH-1:0] m, input int gl, input int sd, input int sl,
                           input int gp, input int rep, input int abort_at,
                           input int rst_at, input bit collide, input int tail);
        int   nbusy;
        int   len;
        exp_t e;
        build_model(m, gl, sd, sl, gp, rep);
        nbusy = model.size() - 1;
        if (collide) model.delete();
        if (abort_at >= 1 && abort_at <= nbusy) begin
            for (int i = abort_at; i < model.size(); i++) model[i] = '0;
        end
        len = model.size() + tail;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            #2;
            start = 1'b0;
            abort = 1'b0;
            if (c == 0) begin
                start        = 1'b1;
                abort        = collide;
                ch_mask      = m;
                gate_len     = 16'(gl);
                strobe_delay = 16'(sd);
                strobe_len   = 16'(sl);
                gap_len      = 16'(gp);
                repeats      = 8'(rep);
            end else if (c <= nbusy && !collide && (abort_at < 0 || c < abort_at)
                         && (rst_at < 0 || c < rst_at)) begin
                start        = 1'($urandom_range(0, 1));
                ch_mask      = CH'($urandom);
                gate_len     = 16'($urandom_range(0, 9));
                strobe_delay = 16'($urandom_range(0, 9));
                strobe_len   = 16'($urandom_range(0, 9));
                gap_len      = 16'($urandom_range(0, 9));
                repeats      = 8'($urandom_range(0, 3));
            end
            if (c == abort_at) abort = 1'b1;
            if (rst_at >= 0 && c == rst_at + 2) rst = 1'b0;
            if (c < model.size() && !(rst_at >= 0 && c >= rst_at)) e = model[c];
            else e = '0;
            sb.push_back(e);
            if (c == rst_at) begin
                @(posedge clk);
                #1 rst = 1'b1;
            end
        end
        @(negedge clk);
        #2;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #2;
            start = 1'b0;
            abort = 1'b0;
            sb.push_back('0);
        end
    endtask

    initial begin
        int gl, sd, sl, gp, rep, ab;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        // Reset mid-GATE, outputs stay low afterwards
        run_seq(4'b0001, 10, 2, 4, 2, 1, -1, 4, 1'b0, 4);
        idle(2);
        // Single pulse with strobe inside the gate
        run_seq(4'b0001, 8, 2, 3, 0, 0, -1, -1, 1'b0, 2);
        // Repeats with zero gap, then back-to-back restart on the done cycle
        run_seq(4'b1111, 4, 1, 2, 0, 2, -1, -1, 1'b0, 0);
        run_seq(4'b0011, 3, 0, 1, 2, 1, -1, -1, 1'b0, 2);
        // Strobe clipping and overflow, strobe past gate end
        run_seq(4'b0001, 5, 3, 16'hFFFF, 1, 0, -1, -1, 1'b0, 2);
        run_seq(4'b0001, 5, 5, 3, 1, 0, -1, -1, 1'b0, 2);
        // Masking, including all-zero mask
        run_seq(4'b0101, 6, 1, 3, 2, 2, -1, -1, 1'b0, 2);
        run_seq(4'b0000, 3, 0, 2, 1, 1, -1, -1, 1'b0, 2);
        // Abort during GAP, abort in IDLE, start+abort, zero gate length
        run_seq(4'b1111, 4, 0, 2, 3, 2, 5, -1, 1'b0, 3);
        run_seq(4'b1111, 2, 0, 1, 1, 0, 5, -1, 1'b0, 4);
        run_seq(4'b1111, 4, 0, 2, 1, 0, -1, -1, 1'b1, 3);
        run_seq(4'b1111, 0, 0, 2, 1, 0, -1, -1, 1'b0, 2);
        // Random profiles
        for (int n = 0; n < 40; n++) begin
            gl  = $urandom_range(0, 7);
            sd  = $urandom_range(0, 8);
            sl  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : $urandom_range(0, 6);
            gp  = $urandom_range(0, 4);
            rep = $urandom_range(0, 3);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
            run_seq(CH'($urandom), gl, sd, sl, gp, rep, ab, -1, 1'b0, $urandom_range(0, 2));
        end
        idle(2);
        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
